// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches req starting one past 'last',
// wrapping at N-1 -> 0, and reports the first set index.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] winner
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_EXT = (IW + 1)'(N);

    logic [IW-1:0] rot_idx [N];
    logic [N-1:0]  rot;

    // rot[k] is the requester k+1 places after the last grant.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum         = {1'b0, last} + (IW + 1)'(gi + 1);
            assign rot_idx[gi] = (sum >= N_EXT) ? IW'(sum - N_EXT) : IW'(sum);
            assign rot[gi]     = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any    = 1'b1;
                winner = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, one byte per grant.
// Define UART_ARB_LOCK_EN to keep the channel with a requester until its req_last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = UART_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]         req_last,
`endif
    output logic [N_REQ-1:0]         req_ack,
    output logic [WIDTH-1:0]         tx_byte,
    output logic                     tx_req,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state_reg, state_next;
    logic [N_REQ-1:0] req_ack_reg;
    logic [WIDTH-1:0] tx_byte_reg;
    logic             tx_req_reg;
    logic [IW-1:0]    rr_ptr_reg;

    logic             pick_any;
    logic [IW-1:0]    pick_id;
    logic [IW-1:0]    win_id;
    logic             grant;
    logic [WIDTH-1:0] data_slice [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_slice[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (req),
        .last   (rr_ptr_reg),
        .any    (pick_any),
        .winner (pick_id)
    );

`ifdef UART_ARB_LOCK_EN
    logic lock_reg, lock_next;

    // A held lock pins the grant to the last winner; others wait even if it drops req.
    assign win_id = lock_reg ? rr_ptr_reg : pick_id;
    assign grant  = (state_reg == ARB_IDLE) && !tx_busy &&
                    (lock_reg ? req[rr_ptr_reg] : pick_any);

    always_comb begin
        lock_next = lock_reg;
        if (grant) begin
            lock_next = !req_last[win_id];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_reg <= 1'b0;
        end else begin
            lock_reg <= lock_next;
        end
    end
`else
    assign win_id = pick_id;
    assign grant  = (state_reg == ARB_IDLE) && !tx_busy && pick_any;
`endif

    // HOLD covers the cycle in which the UART may not yet have raised busy.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: if (grant) state_next = ARB_HOLD;
            ARB_HOLD: state_next = ARB_WAIT;
            ARB_WAIT: if (!tx_busy) state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ARB_IDLE;
            tx_req_reg  <= 1'b0;
            req_ack_reg <= '0;
            tx_byte_reg <= '0;
            rr_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            tx_req_reg  <= grant;
            req_ack_reg <= '0;
            if (grant) begin
                req_ack_reg[win_id] <= 1'b1;
                tx_byte_reg         <= data_slice[win_id];
                rr_ptr_reg          <= win_id;
            end
        end
    end

    assign req_ack  = req_ack_reg;
    assign tx_byte  = tx_byte_reg;
    assign tx_req   = tx_req_reg;
    assign grant_id = rr_ptr_reg;

endmodule
